// File: rtl/bus_ctrl_gen_if.sv
// Status, handshake and command-strobe bundle between the CPU side and the
// bus controller. The controller takes the master modport.
interface bus_ctrl_gen_if;
    logic [2:0] s_n;
    logic       aen_n;
    logic       cen;
    logic       rdy;
    logic       mrdc_n;
    logic       mwtc_n;
    logic       amwc_n;
    logic       iorc_n;
    logic       iowc_n;
    logic       aiowc_n;
    logic       inta_n;
    logic       dtr;
    logic       den;
    logic       mce;
    logic       ale;
    logic       busy;
    logic       timeout;

    modport master (
        input  s_n, aen_n, cen, rdy,
        output mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n,
        output dtr, den, mce, ale, busy, timeout
    );

    modport slave (
        output s_n, aen_n, cen, rdy,
        input  mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n,
        input  dtr, den, mce, ale, busy, timeout
    );
endinterface

// File: rtl/bus_ctrl_gen.sv
// 8288-class bus controller: decodes CPU status into command strobes with a
// programmable command width, READY wait states and an optional wait timeout.
//
// state | meaning
// IDLE  | no bus cycle; waiting for an active status (and aen_n in system-bus mode)
// T1    | address phase, ale high, command latched
// T2    | command width stretch, cmd counter counts down to zero
// T3    | first READY sample
// TW    | wait state, wait counter runs until READY or timeout
// T4    | command release, back to IDLE
module bus_ctrl_gen #(
    parameter int unsigned CMD_MIN  = 1,
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned IOB_MODE = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_ctrl_gen_if.master bus
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [3:0] CMD_LOAD = 4'(CMD_MIN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_TW,
        ST_T4
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_INTA,
        CMD_IORD,
        CMD_IOWR,
        CMD_MRD,
        CMD_MWR
    } cmd_t;

    state_t            state, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [3:0]        cmd_cnt, cmd_cnt_d;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic              start_ok;

    function automatic cmd_t cmd_decode(input logic [2:0] s);
        case (s)
            3'b000:         cmd_decode = CMD_INTA;
            3'b001:         cmd_decode = CMD_IORD;
            3'b010:         cmd_decode = CMD_IOWR;
            3'b100, 3'b101: cmd_decode = CMD_MRD;
            3'b110:         cmd_decode = CMD_MWR;
            default:        cmd_decode = CMD_NONE;
        endcase
    endfunction

    assign start_ok = (bus.s_n != 3'b011) && (bus.s_n != 3'b111) &&
                      ((IOB_MODE != 0) || !bus.aen_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_q     <= CMD_NONE;
            cmd_cnt   <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_d;
            cmd_q     <= cmd_d;
            cmd_cnt   <= cmd_cnt_d;
            wait_cnt  <= wait_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state;
        cmd_d      = cmd_q;
        cmd_cnt_d  = cmd_cnt;
        wait_cnt_d = wait_cnt;
        timeout_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    cmd_d   = cmd_decode(bus.s_n);
                    state_d = ST_T1;
                end
            end
            ST_T1: begin
                cmd_cnt_d = CMD_LOAD;
                state_d   = ST_T2;
            end
            ST_T2: begin
                if (cmd_cnt != 4'd0) begin
                    cmd_cnt_d = cmd_cnt - 4'd1;
                end else begin
                    state_d = ST_T3;
                end
            end
            ST_T3: begin
                if (bus.rdy) begin
                    state_d = ST_T4;
                end else begin
                    wait_cnt_d = '0;
                    state_d    = ST_TW;
                end
            end
            ST_TW: begin
                // Saturating so a disabled timeout can wait indefinitely.
                if (wait_cnt != '1) begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
                if (bus.rdy) begin
                    state_d = ST_T4;
                end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
                    state_d   = ST_T4;
                    timeout_d = 1'b1;
                end
            end
            ST_T4: begin
                cmd_d   = CMD_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                cmd_d   = CMD_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    logic in_t2_tw, in_t3_tw, rd_cyc, wr_cyc, inta_cyc;

    assign in_t2_tw = (state == ST_T2) || (state == ST_T3) || (state == ST_TW);
    assign in_t3_tw = (state == ST_T3) || (state == ST_TW);
    assign inta_cyc = (cmd_q == CMD_INTA);
    assign rd_cyc   = (cmd_q == CMD_MRD) || (cmd_q == CMD_IORD) || inta_cyc;
    assign wr_cyc   = (cmd_q == CMD_MWR) || (cmd_q == CMD_IOWR);

    // Outputs decode only from registered state so s_n cannot glitch them.
    always_comb begin
        bus.mrdc_n  = 1'b1;
        bus.mwtc_n  = 1'b1;
        bus.amwc_n  = 1'b1;
        bus.iorc_n  = 1'b1;
        bus.iowc_n  = 1'b1;
        bus.aiowc_n = 1'b1;
        bus.inta_n  = 1'b1;
        bus.dtr     = 1'b1;
        bus.den     = 1'b0;
        bus.mce     = 1'b0;
        bus.ale     = 1'b0;
        if (bus.cen) begin
            bus.mrdc_n  = !((cmd_q == CMD_MRD)  && in_t2_tw);
            bus.iorc_n  = !((cmd_q == CMD_IORD) && in_t2_tw);
            bus.inta_n  = !(inta_cyc && in_t2_tw);
            bus.amwc_n  = !((cmd_q == CMD_MWR)  && in_t2_tw);
            bus.aiowc_n = !((cmd_q == CMD_IOWR) && in_t2_tw);
            bus.mwtc_n  = !((cmd_q == CMD_MWR)  && in_t3_tw);
            bus.iowc_n  = !((cmd_q == CMD_IOWR) && in_t3_tw);
            bus.dtr     = !(rd_cyc && (state != ST_IDLE));
            bus.den     = (rd_cyc && in_t2_tw) ||
                          (wr_cyc && ((state == ST_T1) || in_t2_tw));
            bus.mce     = inta_cyc && (state == ST_T1) && (IOB_MODE == 0);
            bus.ale     = (state == ST_T1);
        end
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_bus_ctrl_gen.sv
// Directed bench for bus_ctrl_gen: counts strobe widths per bus cycle and
// compares them to hand-derived values on two parameterisations.
module tb_bus_ctrl_gen;

    logic       clk;
    logic       rst_n;
    logic [2:0] s_n;
    logic       aen_n;
    logic       cen;
    logic       rdy;

    int n_checks = 0;
    int n_errors = 0;

    bus_ctrl_gen_if bus_a ();
    bus_ctrl_gen_if bus_b ();

    assign bus_a.s_n = s_n;   assign bus_b.s_n = s_n;
    assign bus_a.aen_n = aen_n; assign bus_b.aen_n = aen_n;
    assign bus_a.cen = cen;   assign bus_b.cen = cen;
    assign bus_a.rdy = rdy;   assign bus_b.rdy = rdy;

    bus_ctrl_gen #(.CMD_MIN(1), .TIMEOUT(15), .IOB_MODE(0)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.master)
    );

    bus_ctrl_gen #(.CMD_MIN(3), .TIMEOUT(0), .IOB_MODE(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit positions in the observation vector.
    localparam int B_MRDC = 12, B_MWTC = 11, B_AMWC = 10, B_IORC = 9, B_IOWC = 8;
    localparam int B_AIOWC = 7, B_INTA = 6, B_DTR = 5, B_DEN = 4, B_MCE = 3;
    localparam int B_ALE = 2, B_BUSY = 1, B_TO = 0;
    // Inverts the active-low lines so a 1 always means "active".
    localparam logic [12:0] ACT_MASK = 13'h1FE0;

    wire [12:0] out_a = {bus_a.mrdc_n, bus_a.mwtc_n, bus_a.amwc_n, bus_a.iorc_n,
                         bus_a.iowc_n, bus_a.aiowc_n, bus_a.inta_n, bus_a.dtr,
                         bus_a.den, bus_a.mce, bus_a.ale, bus_a.busy, bus_a.timeout};
    wire [12:0] out_b = {bus_b.mrdc_n, bus_b.mwtc_n, bus_b.amwc_n, bus_b.iorc_n,
                         bus_b.iowc_n, bus_b.aiowc_n, bus_b.inta_n, bus_b.dtr,
                         bus_b.den, bus_b.mce, bus_b.ale, bus_b.busy, bus_b.timeout};

    int cnt [13];
    int any_act;
    int to_idx;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts one cycle with status st; rdy is sampled high from edge rdy_edge on.
    // Tallies active samples per output while the selected DUT is busy.
    task automatic run_cycle(input bit sel, input logic [2:0] st, input int rdy_edge);
        logic [12:0] act;
        bit done;
        done = 1'b0;
        any_act = 0;
        to_idx = -1;
        for (int i = 0; i < 13; i++) cnt[i] = 0;
        @(negedge clk);
        s_n = st;
        rdy = (rdy_edge <= 0);
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            act = (sel ? out_b : out_a) ^ ACT_MASK;
            if (k == 0) s_n = 3'b111;
            if (act[B_BUSY]) begin
                for (int i = 0; i < 13; i++) cnt[i] += int'(act[i]);
                if (act[12:2] != 11'd0) any_act++;
                if (act[B_TO] && to_idx < 0) to_idx = k;
            end else begin
                done = 1'b1;
            end
            rdy = (k + 1 >= rdy_edge);
        end
        if (!done) check("cycle_end_bound", 0, 1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        s_n = 3'b111;
        rdy = 1'b1;
        for (int k = 0; k < 100 && !idle; k++) begin
            @(negedge clk);
            idle = !bus_a.busy && !bus_b.busy;
        end
        if (!idle) check("idle_bound", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        s_n   = 3'b101;
        aen_n = 1'b0;
        cen   = 1'b1;
        rdy   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs_a", int'(out_a), int'(13'h1FE0));
        check("reset_outputs_b", int'(out_b), int'(13'h1FE0));
        s_n = 3'b111;
        rst_n = 1'b1;
        @(negedge clk);

        // Memory read, defaults.
        run_cycle(1'b0, 3'b101, 0);
        check("mrd_mrdc", cnt[B_MRDC], 2);
        check("mrd_ale",  cnt[B_ALE], 1);
        check("mrd_dtr",  cnt[B_DTR], 4);
        check("mrd_den",  cnt[B_DEN], 2);
        check("mrd_busy", cnt[B_BUSY], 4);
        check("mrd_mwtc", cnt[B_MWTC], 0);
        wait_idle();

        // Memory write.
        run_cycle(1'b0, 3'b110, 0);
        check("mwr_amwc", cnt[B_AMWC], 2);
        check("mwr_mwtc", cnt[B_MWTC], 1);
        check("mwr_den",  cnt[B_DEN], 3);
        check("mwr_dtr",  cnt[B_DTR], 0);
        check("mwr_busy", cnt[B_BUSY], 4);
        wait_idle();

        // IO read with three wait states.
        run_cycle(1'b0, 3'b001, 6);
        check("iord_iorc",    cnt[B_IORC], 5);
        check("iord_timeout", cnt[B_TO], 0);
        check("iord_busy",    cnt[B_BUSY], 7);
        wait_idle();

        // IO write with READY stuck low: forced termination.
        run_cycle(1'b0, 3'b010, 100);
        check("iowr_aiowc",   cnt[B_AIOWC], 17);
        check("iowr_iowc",    cnt[B_IOWC], 16);
        check("iowr_timeout", cnt[B_TO], 1);
        check("iowr_to_in_t4", to_idx, 18);
        check("iowr_busy",    cnt[B_BUSY], 19);
        wait_idle();

        // INTA with commands disabled, then enabled.
        cen = 1'b0;
        run_cycle(1'b0, 3'b000, 0);
        check("inta_cen0_busy", cnt[B_BUSY], 4);
        check("inta_cen0_outs", any_act, 0);
        wait_idle();
        cen = 1'b1;
        run_cycle(1'b0, 3'b000, 0);
        check("inta_mce",  cnt[B_MCE], 1);
        check("inta_inta", cnt[B_INTA], 2);
        check("inta_dtr",  cnt[B_DTR], 4);
        check("inta_den",  cnt[B_DEN], 2);
        wait_idle();

        // aen_n high: system-bus DUT ignores the status, I/O-bus DUT runs.
        aen_n = 1'b1;
        run_cycle(1'b0, 3'b101, 0);
        check("aen_sys_busy", cnt[B_BUSY], 0);
        wait_idle();
        run_cycle(1'b1, 3'b101, 0);
        check("aen_iob_busy", cnt[B_BUSY], 6);
        check("aen_iob_mrdc", cnt[B_MRDC], 4);
        check("aen_iob_ale",  cnt[B_ALE], 1);
        check("aen_iob_mce",  cnt[B_MCE], 0);
        wait_idle();
        aen_n = 1'b0;

        // Timeout disabled: long READY stall, no forced termination.
        run_cycle(1'b1, 3'b001, 25);
        check("notimeout_iorc", cnt[B_IORC], 24);
        check("notimeout_busy", cnt[B_BUSY], 26);
        check("notimeout_to",   cnt[B_TO], 0);
        wait_idle();

        // Asynchronous reset during T3 truncates the strobe.
        @(negedge clk);
        s_n = 3'b101;
        rdy = 1'b0;
        @(negedge clk);
        s_n = 3'b111;
        repeat (2) @(negedge clk);
        check("rst_mid_mrdc_before", int'(bus_a.mrdc_n), 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_mrdc_after", int'(bus_a.mrdc_n), 1);
        check("rst_mid_busy",       int'(bus_a.busy), 0);
        check("rst_mid_dtr",        int'(bus_a.dtr), 1);
        @(negedge clk);
        rst_n = 1'b1;
        rdy = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_ctrl_gen.md
Name: bus_ctrl_gen

Overview:
Parametrised 8288-class bus controller that decodes the 3-bit CPU status into memory, I/O and interrupt-acknowledge command strobes, plus ALE, DT/R, DEN and MCE. It is the successor to the fixed 4-state controller and adds a programmable minimum command width, READY-driven wait states with timeout, an I/O-bus mode, and both normal and advanced write strobes. It sits between the CPU status pins and the system/expansion bus command lines.

Parameters:
CMD_MIN, 1, number of T2 cycles before READY is first sampled (1..15).
TIMEOUT, 15, maximum TW cycles before forced termination; 0 disables the timeout.
IOB_MODE, 0, 0 = system bus (cycle start gated by aen_n); 1 = I/O bus (aen_n ignored).

Ports:
clk  input  1  bus clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
s_n  input  3  CPU status: 000 INTA, 001 IO read, 010 IO write, 011 halt, 100 fetch, 101 mem read, 110 mem write, 111 passive.
aen_n  input  1  address enable, active low; used only when IOB_MODE=0.
cen  input  1  command enable; 0 forces all outputs to their inactive levels.
rdy  input  1  bus READY, sampled in T3 and TW.
mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n  output  1 each  active-low commands.
dtr  output  1  data transmit (1) / receive (0).
den  output  1  data enable, active high.
mce  output  1  master cascade enable, active high.
ale  output  1  address latch enable, active high.
busy  output  1  high whenever state != IDLE.
timeout  output  1  one-cycle pulse when a cycle is force-terminated.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, latched command=none, counters=0. Outputs: all command lines 1, dtr=1, den=0, mce=0, ale=0, busy=0, timeout=0.
- States: IDLE, T1, T2, T3, TW, T4. Outputs decode combinationally from the state register and the latched command. They are glitch-free with respect to s_n.
- Cycle start: in IDLE, a cycle is active when s_n is neither 011 nor 111, and additionally aen_n=0 when IOB_MODE=0.
  - On the edge where the start condition holds, the decoded command is latched and IDLE->T1.
  - The latched command holds until T4, so s_n changes after T1 are ignored.
  - Fetch (100) and mem read (101) both decode to mrdc.
- T1: ale=1. mce=1 when the latched command is INTA and IOB_MODE=0. Next state is T2 with the cmd counter loaded to CMD_MIN-1.
- T2: stays in T2 while the counter != 0, decrementing each cycle; then goes to T3.
- T3: if rdy=1, go to T4. If rdy=0, go to TW with the wait counter cleared.
- TW: the wait counter increments each cycle.
  - If rdy=1, go to T4.
  - Else if TIMEOUT!=0 and the wait counter == TIMEOUT-1, go to T4 and assert timeout during that T4 cycle.
  - rdy has priority over timeout in the same cycle.
- T4: all commands deasserted, den=0; next state IDLE. A new cycle is accepted no earlier than the first IDLE edge (no back-to-back start from T4).
- Command assertion by state:
  - Reads (mrdc, iorc) and inta: asserted in T2, T3 and TW.
  - Advanced writes (amwc, aiowc): asserted in T2, T3 and TW.
  - Normal writes (mwtc, iowc): asserted in T3 and TW only.
- dtr: 0 in T1..T4 for read and INTA cycles; 1 otherwise.
- den:
  - Read/INTA cycles: 1 in T2, T3, TW.
  - Write cycles: 1 in T1, T2, T3, TW.
- cen=0: the FSM and counters keep running, but every output is forced inactive (commands 1, dtr=1, den=0, mce=0, ale=0). busy and timeout are not gated.
- Counter widths: 4 bits for the cmd counter; the wait counter is sized to hold TIMEOUT. The wait counter saturates when TIMEOUT=0.
- rst_n asserted mid-cycle: immediate return to reset values; any partial strobe is truncated.

Test Plan:
1. Defaults, s_n=101, aen_n=0, rdy=1 → ale high 1 cycle; mrdc_n low exactly 2 cycles (T2,T3); dtr=0 for 4 cycles; den high 2 cycles; busy high 4 cycles.
2. s_n=110, rdy=1 → amwc_n low 2 cycles, mwtc_n low 1 cycle (T3), den high T1..T3, dtr=1 throughout.
3. s_n=001, rdy held 0 for 3 cycles after T3 → iorc_n low 2+3=5 cycles; timeout stays 0.
4. TIMEOUT=15, s_n=010, rdy stuck 0 → aiowc_n low 1+1+15=17 cycles; timeout pulses exactly once in T4; busy drops next cycle.
5. s_n=000 with cen=0, then repeated with cen=1 → first pass: busy toggles but all outputs stay inactive; second pass: mce high in T1, inta_n low 2 cycles.
6. IOB_MODE=0 with aen_n=1 and s_n=101 → no cycle started. IOB_MODE=1 with the same stimulus → cycle runs. rst_n pulsed low during T3 → mrdc_n returns to 1 asynchronously and state=IDLE.
